phase_gen: RTL and testbench

- Phase generator: the stage directly upstream of sincos. Produces a stream of Q3.13 signed phase words, wrapped into [-pi, pi), with a programmable increment and offset.
- Replaces the open-loop ramp used to exercise sincos. Wrap-around is modular, not a snap to -pi.
- Output is a valid/ready stream. It connects to sincos phase/phase_tvalid; phase_tready is tied high when sincos is the consumer.

---
 rtl/phase_pkg.sv | 15 +
 rtl/phase_wrap.sv | 34 +++
 rtl/phase_gen.sv | 117 +++++++++++
 tb/tb_phase_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared Q3.13 phase constants and types for the phase generator and sincos.
package phase_pkg;
  localparam int W           = 16;
  localparam int PI_POS      = 25736;
  localparam int PI_NEG      = -PI_POS;
  localparam int TWO_PI      = 2 * PI_POS;
  localparam int DEFAULT_INC = 256;

  typedef logic signed [W-1:0] phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/phase_wrap.sv
// Modular wrap of a W+2 bit sum into [-pi, pi), plus a symmetric clamp of a
// W bit input to [-(pi-1), pi-1].
module phase_wrap #(
  parameter int W      = 16,
  parameter int PI_POS = 25736,
  parameter int TWO_PI = 51472
) (
  input  logic signed [W+1:0] x,
  input  logic signed [W-1:0] lim_in,
  output logic signed [W-1:0] wrapped,
  output logic signed [W-1:0] clamped
);
  localparam logic signed [W+1:0] PI_P  = (W+2)'(PI_POS);
  localparam logic signed [W+1:0] PI_N  = (W+2)'(-PI_POS);
  localparam logic signed [W+1:0] TWO   = (W+2)'(TWO_PI);
  localparam logic signed [W-1:0] LIM_P = W'(PI_POS - 1);
  localparam logic signed [W-1:0] LIM_N = W'(-(PI_POS - 1));

  logic signed [W+1:0] y;

  // Inputs are at most one turn out of range, so a single correction suffices.
  always_comb begin
    y = x;
    if (x >= PI_P)     y = x - TWO;
    else if (x < PI_N) y = x + TWO;
    wrapped = W'(y);
  end

  always_comb begin
    clamped = lim_in;
    if (lim_in > LIM_P)      clamped = LIM_P;
    else if (lim_in < LIM_N) clamped = LIM_N;
  end
endmodule

// File: rtl/phase_gen.sv
// Phase accumulator feeding sincos: emits wrapped Q3.13 phase words on a
// valid/ready stream with a programmable increment and offset.
module phase_gen #(
  parameter int W           = phase_pkg::W,
  parameter int PI_POS      = phase_pkg::PI_POS,
  parameter int TWO_PI      = phase_pkg::TWO_PI,
  parameter int DEFAULT_INC = phase_pkg::DEFAULT_INC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic signed [W-1:0] inc_in,
  input  logic                inc_load,
  input  logic signed [W-1:0] offset_in,
  output logic signed [W-1:0] phase,
  output logic                phase_tvalid,
  input  logic                phase_tready
);
  import phase_pkg::*;

  localparam int XW = W + 2;

  state_t state, state_n;

  logic signed [W-1:0]  acc, inc_reg, inc_pend, offset_reg;
  logic signed [W-1:0]  inc_eff, base, acc_n, phase_n, inc_cl, off_cl;
  logic signed [XW-1:0] acc_x, off_x;
  logic                 clr_pend;
  logic                 beat, adv, emit, vld_n;

  assign beat = phase_tvalid & phase_tready;

  // A clear that lands on a held word leaves acc already pointing at the next
  // word, so the following advance must not add the increment again.
  always_comb begin
    inc_eff = inc_reg;
    if (clr_pend) inc_eff = '0;
  end

  always_comb begin
    base = acc;
    if (clear)             base = '0;
    else if (state == RUN) base = acc_n;
  end

  assign acc_x = XW'(acc) + XW'(inc_eff);
  assign off_x = XW'(base) + XW'(offset_reg);

  phase_wrap #(.W(W), .PI_POS(PI_POS), .TWO_PI(TWO_PI)) u_acc_wrap (
    .x       (acc_x),
    .lim_in  (inc_in),
    .wrapped (acc_n),
    .clamped (inc_cl)
  );

  phase_wrap #(.W(W), .PI_POS(PI_POS), .TWO_PI(TWO_PI)) u_off_wrap (
    .x       (off_x),
    .lim_in  (offset_in),
    .wrapped (phase_n),
    .clamped (off_cl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en)         state_n = RUN;
      RUN:     if (beat & !en) state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_comb begin
    adv   = 1'b0;
    emit  = 1'b0;
    vld_n = phase_tvalid;
    case (state)
      IDLE: begin
        emit  = en;
        vld_n = en;
      end
      RUN: begin
        adv  = beat;
        emit = beat & en;
        if (beat) vld_n = en;
      end
      default: vld_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase        <= '0;
      phase_tvalid <= 1'b0;
      acc          <= '0;
      inc_reg      <= W'(DEFAULT_INC);
      inc_pend     <= W'(DEFAULT_INC);
      offset_reg   <= '0;
      clr_pend     <= 1'b0;
    end else begin
      offset_reg   <= off_cl;
      phase_tvalid <= vld_n;
      if (emit)     phase    <= phase_n;
      if (inc_load) inc_pend <= inc_cl;
      if (adv)      inc_reg  <= inc_pend;
      if (clear)    acc      <= '0;
      else if (adv) acc      <= acc_n;
      if (clear)    clr_pend <= (state == RUN) & phase_tvalid & !beat;
      else if (adv) clr_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen with hand-computed expected phase words.
module tb_phase_gen;
  import phase_pkg::*;

  logic   clk = 1'b0, rst = 1'b1, en = 1'b0, clear = 1'b0;
  logic   inc_load = 1'b0, tready = 1'b1, tvalid;
  phase_t inc_in = '0, offset_in = '0, phase;
  int     n_chk = 0, n_err = 0;

  phase_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clear        (clear),
    .inc_in       (inc_in),
    .inc_load     (inc_load),
    .offset_in    (offset_in),
    .phase        (phase),
    .phase_tvalid (tvalid),
    .phase_tready (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from a clock edge and checks the outputs drop at once.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_phase"}, phase, 0);
    check({tag, "_vld"}, 32'(tvalid), 0);
    en = 1'b0; clear = 1'b0; inc_load = 1'b0; tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1;
    do_reset("rst");
    tick();
    check("idle_vld", 32'(tvalid), 0);

    // Default increment, modular wrap past +pi
    en = 1'b1;
    tick();
    check("t1_lat_vld", 32'(tvalid), 1);
    check("t1_w0", phase, 0);
    tick(); check("t1_w1", phase, 256);
    tick(); check("t1_w2", phase, 512);
    repeat (98) tick();
    check("t1_w100", phase, 25600);
    tick(); check("t1_wrap", phase, -25616);

    // Async reset mid-stream, then a negative increment
    #3;
    do_reset("t2_async");
    inc_in = -16'sd256; inc_load = 1'b1;
    tick();
    inc_load = 1'b0; en = 1'b1;
    tick(); check("t2_w0", phase, 0);
    tick(); check("t2_old_inc", phase, 256);
    tick(); check("t2_new_inc", phase, 0);
    repeat (100) tick();
    check("t2_low", phase, -25600);
    tick(); check("t2_wrap", phase, 25616);
    tick(); check("t2_after", phase, 25360);

    // Offset path and offset clamp
    do_reset("t3_rst");
    offset_in = 16'sd25000; inc_in = 16'sd744; inc_load = 1'b1;
    tick();
    inc_load = 1'b0; en = 1'b1;
    tick(); check("t3_w0", phase, 25000);
    tick(); check("t3_w1", phase, 25256);
    tick(); check("t3_acc1000", phase, -25472);
    offset_in = 16'sd30000;
    tick(); check("t3_old_off", phase, -24728);
    tick(); check("t3_clamp", phase, -23249);

    // Backpressure hold
    do_reset("t4_rst");
    offset_in = '0; en = 1'b1;
    tick(); check("t4_w0", phase, 0);
    repeat (4) tick();
    check("t4_w4", phase, 1024);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold", phase, 1024);
      check("t4_hold_vld", 32'(tvalid), 1);
    end
    tready = 1'b1;
    tick(); check("t4_resume", phase, 1280);

    // en dropped while a word is held
    tready = 1'b0; en = 1'b0;
    tick();
    check("t5_held", phase, 1280);
    check("t5_held_vld", 32'(tvalid), 1);
    tready = 1'b1;
    tick(); check("t5_drop_vld", 32'(tvalid), 0);
    tick(); check("t5_idle_vld", 32'(tvalid), 0);
    en = 1'b1;
    tick();
    check("t5_resume", phase, 1536);
    check("t5_resume_vld", 32'(tvalid), 1);

    // clear with a beat, then clear on a held word
    do_reset("t6_rst");
    offset_in = 16'sd100; inc_in = 16'sd4744; inc_load = 1'b1;
    tick();
    inc_load = 1'b0; en = 1'b1;
    tick(); check("t6_w0", phase, 100);
    tick(); check("t6_w1", phase, 356);
    tick(); check("t6_acc5000", phase, 5100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_clr_beat", phase, 100);
    tick(); check("t6_after_clr", phase, 4844);
    tready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_clr_hold", phase, 4844);
    tick(); check("t6_clr_hold2", phase, 4844);
    tready = 1'b1;
    tick(); check("t6_clr_pend", phase, 100);
    tick(); check("t6_clr_next", phase, 4844);
    #3;
    do_reset("t6_async");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
